// File: rtl/d16_pipe_ctrl_if.sv
// Control bundle between the d16 pipeline sequencer and its datapath.
// The datapath side (master) supplies hazard, memory, branch and halt
// status; the sequencer (slave) returns stage enables, squash strobes and
// its status counters.
interface d16_pipe_ctrl_if #(
   parameter int REG_W = 3
);
   logic             id_uses_a;
   logic             id_uses_b;
   logic [REG_W-1:0] id_src_a;
   logic [REG_W-1:0] id_src_b;
   logic             ex_wr;
   logic [REG_W-1:0] ex_dst;
   logic             wb_wr;
   logic [REG_W-1:0] wb_dst;
   logic             mem_req;
   logic             mem_ack;
   logic             branch_taken;
   logic             halt_req;
   logic             resume;
   logic             stat_clr;

   logic             en_if;
   logic             en_id;
   logic             en_ex;
   logic             en_wb;
   logic             flush_id;
   logic             flush_ex;
   logic             flush_wb;
   logic             pc_load;
   logic             halted;
   logic             err_timeout;
   logic [15:0]      stall_cnt;

   modport master (
      output id_uses_a, id_uses_b, id_src_a, id_src_b,
             ex_wr, ex_dst, wb_wr, wb_dst,
             mem_req, mem_ack, branch_taken, halt_req, resume, stat_clr,
      input  en_if, en_id, en_ex, en_wb,
             flush_id, flush_ex, flush_wb,
             pc_load, halted, err_timeout, stall_cnt
   );

   modport slave (
      input  id_uses_a, id_uses_b, id_src_a, id_src_b,
             ex_wr, ex_dst, wb_wr, wb_dst,
             mem_req, mem_ack, branch_taken, halt_req, resume, stat_clr,
      output en_if, en_id, en_ex, en_wb,
             flush_id, flush_ex, flush_wb,
             pc_load, halted, err_timeout, stall_cnt
   );
endinterface

// File: rtl/d16_pipe_ctrl.sv
// Sequencer for the four d16 pipeline register stages (IF->ID, ID->EX,
// EX->WB, WB). Produces per-stage enables and NOP-squash strobes for RAW
// stalls, memory-wait freezes, taken-branch flushes and halt/drain, and
// keeps a saturating count of fetch-stall cycles. Stage controls are
// combinational decodes of state and inputs; only state and counters are
// registered.
module d16_pipe_ctrl #(
   parameter int REG_W       = 3,
   parameter int DRAIN_CYC   = 3,
   parameter int MEM_TIMEOUT = 255
) (
   input logic            sys_clk,
   input logic            sys_rst_n,
   d16_pipe_ctrl_if.slave ctl
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_MEM   = 3'd2,
      S_DRAIN = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   // MEM_TIMEOUT is legal in 1..255, so it always fits the 8-bit wait counter.
   localparam logic [7:0] MEM_LIMIT  = 8'(MEM_TIMEOUT);
   localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC);

   state_t      state_q,     state_d;
   logic [7:0]  mem_cnt_q,   mem_cnt_d;
   logic [7:0]  drain_cnt_q, drain_cnt_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        err_q,       err_d;

   logic [REG_W-1:0] src_a;
   logic [REG_W-1:0] src_b;
   logic [REG_W-1:0] ex_dst;
   logic [REG_W-1:0] wb_dst;
   logic             haz_a;
   logic             haz_b;
   logic             haz;

   logic en_if_c, en_id_c, en_ex_c, en_wb_c;
   logic flush_id_c, flush_ex_c, flush_wb_c;
   logic pc_load_c, halted_c;
   logic stall_cycle;

   assign src_a  = ctl.id_src_a;
   assign src_b  = ctl.id_src_b;
   assign ex_dst = ctl.ex_dst;
   assign wb_dst = ctl.wb_dst;

   // An ID operand is hazardous when an older in-flight instruction will
   // still write that register.
   assign haz_a = ctl.id_uses_a &
                  ((ctl.ex_wr & (src_a == ex_dst)) | (ctl.wb_wr & (src_a == wb_dst)));
   assign haz_b = ctl.id_uses_b &
                  ((ctl.ex_wr & (src_b == ex_dst)) | (ctl.wb_wr & (src_b == wb_dst)));
   assign haz   = haz_a | haz_b;

   // Next-state and stage-control decode; every output defaults to idle.
   always_comb begin
      state_d     = state_q;
      mem_cnt_d   = mem_cnt_q;
      drain_cnt_d = drain_cnt_q;
      err_d       = err_q;
      en_if_c     = 1'b0;
      en_id_c     = 1'b0;
      en_ex_c     = 1'b0;
      en_wb_c     = 1'b0;
      flush_id_c  = 1'b0;
      flush_ex_c  = 1'b0;
      flush_wb_c  = 1'b0;
      pc_load_c   = 1'b0;
      halted_c    = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_RUN;
         end

         S_RUN: begin
            if (ctl.branch_taken) begin
               // Branch resolution outranks everything: squash the two
               // younger wrong-path instructions and redirect fetch.
               {en_if_c, en_id_c, en_ex_c, en_wb_c} = 4'b1111;
               flush_id_c = 1'b1;
               flush_ex_c = 1'b1;
               pc_load_c  = 1'b1;
            end else if (ctl.mem_req && !ctl.mem_ack) begin
               // Access missed this cycle: freeze front end, let WB retire
               // and feed it bubbles until memory answers.
               en_wb_c    = 1'b1;
               flush_wb_c = 1'b1;
               mem_cnt_d  = 8'd1;
               state_d    = S_MEM;
            end else if (haz) begin
               // Hold IF/ID for one cycle and inject a bubble into EX.
               en_ex_c    = 1'b1;
               en_wb_c    = 1'b1;
               flush_ex_c = 1'b1;
            end else if (ctl.halt_req) begin
               // Stop fetching and let the older instructions drain out.
               en_id_c     = 1'b1;
               en_ex_c     = 1'b1;
               en_wb_c     = 1'b1;
               flush_id_c  = 1'b1;
               drain_cnt_d = 8'd1;
               state_d     = S_DRAIN;
            end else begin
               {en_if_c, en_id_c, en_ex_c, en_wb_c} = 4'b1111;
            end
         end

         S_MEM: begin
            if (ctl.mem_ack) begin
               {en_if_c, en_id_c, en_ex_c, en_wb_c} = 4'b1111;
               mem_cnt_d = 8'd0;
               state_d   = S_RUN;
            end else if (mem_cnt_q == MEM_LIMIT) begin
               // Give up on the access: release the pipe but keep WB
               // squashed so the aborted instruction never retires.
               {en_if_c, en_id_c, en_ex_c, en_wb_c} = 4'b1111;
               flush_wb_c = 1'b1;
               err_d      = 1'b1;
               mem_cnt_d  = 8'd0;
               state_d    = S_RUN;
            end else begin
               en_wb_c    = 1'b1;
               flush_wb_c = 1'b1;
               mem_cnt_d  = mem_cnt_q + 8'd1;
            end
         end

         S_DRAIN: begin
            en_id_c     = 1'b1;
            en_ex_c     = 1'b1;
            en_wb_c     = 1'b1;
            flush_id_c  = 1'b1;
            drain_cnt_d = drain_cnt_q + 8'd1;
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = S_HALT;
            end
         end

         S_HALT: begin
            halted_c = 1'b1;
            if (ctl.resume) begin
               {en_if_c, en_id_c, en_ex_c, en_wb_c} = 4'b1111;
               state_d = S_RUN;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Only fetch stalls taken while actually executing count; idle, drain
   // and halt cycles are deliberate and are not charged.
   assign stall_cycle = ((state_q == S_RUN) || (state_q == S_MEM)) && !en_if_c;

   // Saturating stall counter; a clear request beats the increment.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (ctl.stat_clr) begin
         stall_cnt_d = 16'd0;
      end else if (stall_cycle && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   // State and counter registers; reset aborts whatever was in progress.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= S_IDLE;
         mem_cnt_q   <= 8'd0;
         drain_cnt_q <= 8'd0;
         stall_cnt_q <= 16'd0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_cnt_q   <= mem_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         err_q       <= err_d;
      end
   end

   assign ctl.en_if       = en_if_c;
   assign ctl.en_id       = en_id_c;
   assign ctl.en_ex       = en_ex_c;
   assign ctl.en_wb       = en_wb_c;
   assign ctl.flush_id    = flush_id_c;
   assign ctl.flush_ex    = flush_ex_c;
   assign ctl.flush_wb    = flush_wb_c;
   assign ctl.pc_load     = pc_load_c;
   assign ctl.halted      = halted_c;
   assign ctl.err_timeout = err_q;
   assign ctl.stall_cnt   = stall_cnt_q;

endmodule
